// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED display controller.
package led_ctrl_pkg;

    localparam int LED_COUNT = 6;

    typedef enum logic [1:0] {
        MODE_MIRROR = 2'b00,
        MODE_STATUS = 2'b01,
        MODE_WALK   = 2'b10
    } mode_e;

    // Mode cycle order; the unused code falls back to MIRROR.
    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_MIRROR: next_mode = MODE_STATUS;
            MODE_STATUS: next_mode = MODE_WALK;
            default:     next_mode = MODE_MIRROR;
        endcase
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// One switch bit: 2-flop synchronizer followed by a stability-count debouncer.
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            cnt <= '0;
            db  <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            // Any cycle agreeing with the debounced value restarts the count.
            if (s2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                db  <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/led_display_ctrl.sv
// Shares the LED[6:1] bank between switch mirror, CAN status and a walking-one test,
// with Switch[6] acting as a mode-advance button.
module led_display_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int STEP_CYCLES     = 12500000,
    parameter int STALE_CYCLES    = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:1] Switch,
    input  logic [5:0] can_status,
    input  logic       can_status_valid,
    output logic [6:1] LED,
    output logic [1:0] mode
);

    localparam int SCW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int TCW = (STALE_CYCLES > 1) ? $clog2(STALE_CYCLES) : 1;
    localparam logic [SCW-1:0] STEP_MAX  = SCW'(STEP_CYCLES - 1);
    localparam logic [TCW-1:0] STALE_MAX = TCW'(STALE_CYCLES - 1);

    logic [6:1]     sw_db;
    logic           sw6_q;
    mode_e          mode_q;
    logic [SCW-1:0] step_cnt;
    logic           tog;
    logic [6:1]     walk;
    logic [5:0]     status_q;
    logic [TCW-1:0] stale_cnt;
    logic           stale;
    logic           adv;
    logic           mode_bad;
    logic           mode_chg;

    for (genvar i = 1; i <= LED_COUNT; i++) begin : g_db
        switch_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk(clk),
            .rst(rst),
            .raw(Switch[i]),
            .db (sw_db[i])
        );
    end

    assign adv      = sw_db[6] & ~sw6_q;
    assign mode_bad = (mode_q != MODE_MIRROR) && (mode_q != MODE_STATUS) && (mode_q != MODE_WALK);
    assign mode_chg = adv | mode_bad;
    assign mode     = mode_q;

    // Mode FSM with the step timer it restarts on every mode change.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw6_q    <= 1'b0;
            mode_q   <= MODE_MIRROR;
            step_cnt <= '0;
            tog      <= 1'b0;
            walk     <= 6'b000001;
        end else begin
            sw6_q <= sw_db[6];
            if (mode_chg) begin
                mode_q   <= next_mode(mode_q);
                step_cnt <= '0;
                tog      <= 1'b0;
                walk     <= 6'b000001;
            end else if (step_cnt == STEP_MAX) begin
                step_cnt <= '0;
                tog      <= ~tog;
                walk     <= {walk[5:1], walk[6]};
            end else begin
                step_cnt <= step_cnt + SCW'(1);
            end
        end
    end

    // A valid strobe always wins, independent of mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q  <= '0;
            stale_cnt <= '0;
            stale     <= 1'b0;
        end else if (can_status_valid) begin
            status_q  <= can_status;
            stale_cnt <= '0;
            stale     <= 1'b0;
        end else if (stale_cnt == STALE_MAX) begin
            stale <= 1'b1;
        end else begin
            stale_cnt <= stale_cnt + TCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            LED <= '0;
        end else begin
            case (mode_q)
                MODE_MIRROR: LED <= {tog, sw_db[5:1]};
                MODE_STATUS: LED <= stale ? {6{tog}} : status_q;
                MODE_WALK:   LED <= walk;
                default:     LED <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_led_display_ctrl.sv
// Scoreboard bench for led_display_ctrl against a time-based behavioural model.
module tb_led_display_ctrl;
    import led_ctrl_pkg::*;

    localparam int DEB   = 4;
    localparam int STEP  = 8;
    localparam int STALE = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:1] Switch = '0;
    logic [5:0] can_status = '0;
    logic       can_status_valid = 1'b0;
    logic [6:1] LED;
    logic [1:0] mode;

    led_display_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .STEP_CYCLES    (STEP),
        .STALE_CYCLES   (STALE)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .Switch          (Switch),
        .can_status      (can_status),
        .can_status_valid(can_status_valid),
        .LED             (LED),
        .mode            (mode)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:1] led;
        logic [1:0] mode;
    } exp_t;

    exp_t expq[$];
    int   errors = 0;
    int   checks = 0;

    // Model state: raw history per edge, debounced view, and "edges since" counters.
    logic [6:1] m_hist[5];
    logic [6:1] m_db   = '0;
    logic [6:1] m_db_d = '0;
    logic [6:1] m_led  = '0;
    logic [5:0] m_latch = '0;
    int         m_mode  = 0;
    int         m_age   = 0;
    int         m_since = 0;
    logic [6:1] cur = '0;

    task automatic model_edge(input logic [6:1] sw, input logic r, input logic v, input logic [5:0] st);
        logic [6:1] ndb;
        logic [6:1] nled;
        logic       tg;
        bit         all;
        if (r) begin
            for (int i = 0; i < 5; i++) m_hist[i] = '0;
            m_db = '0; m_db_d = '0; m_led = '0; m_latch = '0;
            m_mode = 0; m_age = 0; m_since = 0;
        end else begin
            tg = ((m_age / STEP) % 2) == 1;
            case (m_mode)
                0:       nled = {tg, m_db[5:1]};
                1:       nled = (m_since >= STALE) ? {6{tg}} : m_latch;
                default: nled = 6'(1) << ((m_age / STEP) % 6);
            endcase
            // A bit flips once the synced value has disagreed for DEB straight edges.
            ndb = m_db;
            for (int b = 1; b <= 6; b++) begin
                all = 1;
                for (int i = 1; i <= DEB; i++) if (m_hist[i][b] == m_db[b]) all = 0;
                if (all) ndb[b] = ~m_db[b];
            end
            if (m_db[6] && !m_db_d[6]) begin
                m_mode = (m_mode + 1) % 3;
                m_age  = 0;
            end else begin
                m_age++;
            end
            if (v) begin
                m_latch = st;
                m_since = 0;
            end else if (m_since < 1000) begin
                m_since++;
            end
            m_db_d = m_db;
            m_db   = ndb;
            for (int i = 4; i >= 1; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = sw;
            m_led = nled;
        end
    endtask

    task automatic tick(input logic [6:1] sw, input logic r, input logic v, input logic [5:0] st);
        @(negedge clk);
        Switch = sw; rst = r; can_status_valid = v; can_status = st;
        model_edge(sw, r, v, st);
        expq.push_back('{led: m_led, mode: 2'(m_mode)});
    endtask

    task automatic hold(input logic [6:1] sw, input int n);
        for (int k = 0; k < n; k++) tick(sw, 1'b0, 1'b0, 6'h00);
    endtask

    task automatic press();
        hold(cur | 6'b100000, 10);
        hold(cur & 6'b011111, 10);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            checks++;
            if (LED !== e.led) begin
                errors++;
                if (errors <= 40) $display("FAIL led @%0t: got %b want %b", $time, LED, e.led);
            end
            checks++;
            if (mode !== e.mode) begin
                errors++;
                if (errors <= 40) $display("FAIL mode @%0t: got %b want %b", $time, mode, e.mode);
            end
        end
    end

    initial begin
        for (int i = 0; i < 5; i++) m_hist[i] = '0;
        repeat (3) tick(6'b0, 1'b1, 1'b0, 6'h00);

        // Mirror latency and heartbeat.
        cur = 6'b000101; hold(cur, 40);
        cur = 6'b000000; hold(cur, 12);

        // Short glitch is filtered, a DEB-cycle pulse passes.
        hold(6'b000001, 3); hold(6'b0, 10);
        hold(6'b000001, 4); hold(6'b0, 12);

        // Random bouncing on the mirrored bits.
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 4) == 0) cur[$urandom_range(1, 5)] ^= 1'b1;
            hold(cur, 1);
        end
        cur = '0; hold(cur, 10);

        // Three presses cycle the modes; a long hold advances only once.
        press(); press(); press();
        hold(6'b100000, 100); hold(6'b000000, 10);

        // STATUS: latch, stale blink, recovery, random strobes.
        tick(cur, 1'b0, 1'b1, 6'h2A); hold(cur, 80);
        tick(cur, 1'b0, 1'b1, 6'h15); hold(cur, 20);
        for (int k = 0; k < 150; k++)
            tick(cur, 1'b0, ($urandom_range(0, 29) == 0), 6'($urandom));

        // WALK, leave mid-walk and come back, then reset while stale.
        press(); hold(cur, 60);
        press(); press(); press(); hold(cur, 30);
        tick(cur, 1'b1, 1'b0, 6'h00);
        hold(cur, 5);
        press(); hold(cur, 20);

        // Fully random traffic including the mode button.
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 5) == 0) cur[$urandom_range(1, 5)] ^= 1'b1;
            if ($urandom_range(0, 24) == 0) cur[6] ^= 1'b1;
            tick(cur, ($urandom_range(0, 499) == 0), ($urandom_range(0, 19) == 0), 6'($urandom));
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
